// File: rtl/ulpb_tx_arbiter.sv
// rtl/ulpb_tx_arbiter.sv - four-requester round-robin transmit arbiter for one ulpb node (optional ULPB_TX_ARB_PRIORITY_EN)
module ulpb_tx_arbiter (
    input  logic         CLKIN,
    input  logic         RESET,
    input  logic [3:0]   REQ_TX_REQ,
    input  logic [3:0]   REQ_TX_PEND,
    input  logic [3:0]   REQ_PRIORITY,
    input  logic [31:0]  REQ_TX_ADDR,
    input  logic [127:0] REQ_TX_DATA,
    input  logic [3:0]   REQ_TX_RESP_ACK,
    output logic [3:0]   REQ_TX_ACK,
    output logic [3:0]   REQ_TX_SUCC,
    output logic [3:0]   REQ_TX_FAIL,
    output logic [7:0]   TX_ADDR,
    output logic [31:0]  TX_DATA,
    output logic         TX_REQ,
    output logic         TX_PEND,
    output logic         PRIORITY,
    input  logic         TX_ACK,
    input  logic         TX_SUCC,
    input  logic         TX_FAIL,
    output logic         TX_RESP_ACK,
    output logic         BUSY,
    output logic [1:0]   GRANT_ID
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        ACKLOW  = 3'd2,
        NEXT    = 3'd3,
        RESULT  = 3'd4,
        RESPACK = 3'd5
    } state_t;

    state_t     state;
    logic [1:0] rr;
    logic [3:0] cand;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       win_prio;
    logic       result;
    logic [3:0] owner_mask;
    logic       node_done;
    logic       req_done;

    assign result     = TX_SUCC | TX_FAIL;
    assign owner_mask = 4'b0001 << GRANT_ID;
    // node side is finished once it has dropped its result, or already did so earlier
    assign node_done  = !result || !TX_RESP_ACK;
    // requester side is finished on its ack, or once its flags were already cleared by an earlier ack
    assign req_done   = REQ_TX_RESP_ACK[GRANT_ID] || ((REQ_TX_SUCC | REQ_TX_FAIL) == 4'b0000);

    // Pick the first eligible requester scanning upward from the round-robin pointer
    always_comb begin
`ifdef ULPB_TX_ARB_PRIORITY_EN
        cand = ((REQ_TX_REQ & REQ_PRIORITY) != 4'b0000) ? (REQ_TX_REQ & REQ_PRIORITY) : REQ_TX_REQ;
`else
        cand = REQ_TX_REQ;
`endif
        winner = rr;
        found  = 1'b0;
        idx    = rr;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`ifdef ULPB_TX_ARB_PRIORITY_EN
        win_prio = REQ_PRIORITY[winner];
`else
        win_prio = 1'b0;
`endif
    end

    // Message FSM: grant, per-word handshake with the node, result hand-back, release
    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state       <= IDLE;
            rr          <= 2'd0;
            REQ_TX_ACK  <= 4'b0000;
            REQ_TX_SUCC <= 4'b0000;
            REQ_TX_FAIL <= 4'b0000;
            TX_ADDR     <= 8'h00;
            TX_DATA     <= 32'h0000_0000;
            TX_REQ      <= 1'b0;
            TX_PEND     <= 1'b0;
            PRIORITY    <= 1'b0;
            TX_RESP_ACK <= 1'b0;
            BUSY        <= 1'b0;
            GRANT_ID    <= 2'd0;
        end else begin
            REQ_TX_ACK <= 4'b0000;
            case (state)
                IDLE: begin
                    if (REQ_TX_REQ != 4'b0000) begin
                        TX_ADDR  <= REQ_TX_ADDR[8*winner +: 8];
                        TX_DATA  <= REQ_TX_DATA[32*winner +: 32];
                        TX_PEND  <= REQ_TX_PEND[winner];
                        PRIORITY <= win_prio;
                        GRANT_ID <= winner;
                        BUSY     <= 1'b1;
                        TX_REQ   <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND, ACKLOW, NEXT, RESULT: begin
                    if (result) begin
                        // a result at any point ends the message, aborting any remaining words
                        TX_REQ      <= 1'b0;
                        REQ_TX_SUCC <= {4{TX_SUCC}} & owner_mask;
                        REQ_TX_FAIL <= {4{TX_FAIL}} & owner_mask;
                        TX_RESP_ACK <= 1'b1;
                        state       <= RESPACK;
                    end else if (state == SEND) begin
                        if (TX_ACK) begin
                            TX_REQ     <= 1'b0;
                            REQ_TX_ACK <= owner_mask;
                            state      <= ACKLOW;
                        end
                    end else if (state == ACKLOW) begin
                        if (!TX_ACK) begin
                            state <= TX_PEND ? NEXT : RESULT;
                        end
                    end else if (state == NEXT) begin
                        // only the owner can continue; everyone else waits for the message to end
                        if (REQ_TX_REQ[GRANT_ID]) begin
                            TX_ADDR  <= REQ_TX_ADDR[8*GRANT_ID +: 8];
                            TX_DATA  <= REQ_TX_DATA[32*GRANT_ID +: 32];
                            TX_PEND  <= REQ_TX_PEND[GRANT_ID];
`ifdef ULPB_TX_ARB_PRIORITY_EN
                            PRIORITY <= REQ_PRIORITY[GRANT_ID];
`endif
                            TX_REQ   <= 1'b1;
                            state    <= SEND;
                        end
                    end
                end
                RESPACK: begin
                    if (!result) begin
                        TX_RESP_ACK <= 1'b0;
                    end
                    if (REQ_TX_RESP_ACK[GRANT_ID]) begin
                        REQ_TX_SUCC <= 4'b0000;
                        REQ_TX_FAIL <= 4'b0000;
                    end
                    if (node_done && req_done) begin
                        REQ_TX_SUCC <= 4'b0000;
                        REQ_TX_FAIL <= 4'b0000;
                        TX_RESP_ACK <= 1'b0;
                        TX_ADDR     <= 8'h00;
                        TX_DATA     <= 32'h0000_0000;
                        TX_PEND     <= 1'b0;
                        PRIORITY    <= 1'b0;
                        BUSY        <= 1'b0;
                        GRANT_ID    <= 2'd0;
                        rr          <= GRANT_ID + 2'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// tb/tb_ulpb_tx_arbiter.sv - directed self-checking bench for ulpb_tx_arbiter
module tb_ulpb_tx_arbiter;

    logic         CLKIN = 1'b0;
    logic         RESET = 1'b1;
    logic [3:0]   REQ_TX_REQ = '0;
    logic [3:0]   REQ_TX_PEND = '0;
    logic [3:0]   REQ_PRIORITY = '0;
    logic [31:0]  REQ_TX_ADDR = '0;
    logic [127:0] REQ_TX_DATA = '0;
    logic [3:0]   REQ_TX_RESP_ACK = '0;
    logic [3:0]   REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL;
    logic [7:0]   TX_ADDR;
    logic [31:0]  TX_DATA;
    logic         TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, BUSY;
    logic [1:0]   GRANT_ID;
    logic         TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
    logic [58:0]  all_out;

    int vectors = 0;
    int miscompares = 0;

    ulpb_tx_arbiter dut (
        .CLKIN(CLKIN), .RESET(RESET),
        .REQ_TX_REQ(REQ_TX_REQ), .REQ_TX_PEND(REQ_TX_PEND), .REQ_PRIORITY(REQ_PRIORITY),
        .REQ_TX_ADDR(REQ_TX_ADDR), .REQ_TX_DATA(REQ_TX_DATA), .REQ_TX_RESP_ACK(REQ_TX_RESP_ACK),
        .REQ_TX_ACK(REQ_TX_ACK), .REQ_TX_SUCC(REQ_TX_SUCC), .REQ_TX_FAIL(REQ_TX_FAIL),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND), .PRIORITY(PRIORITY),
        .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
        .TX_RESP_ACK(TX_RESP_ACK), .BUSY(BUSY), .GRANT_ID(GRANT_ID)
    );

    assign all_out = {REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL, TX_ADDR, TX_DATA,
                      TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, BUSY, GRANT_ID};

    always #5 CLKIN = ~CLKIN;

    task automatic apply_reset;
        RESET = 1'b1;
        @(negedge CLKIN);
        RESET = 1'b0;
    endtask

    // owner is in SEND with PEND=0: ack the word, return SUCC, acknowledge it; ends back in IDLE
    task automatic finish_msg;
        TX_ACK = 1'b1;
        @(negedge CLKIN);
        TX_ACK = 1'b0;
        @(negedge CLKIN);
        TX_SUCC = 1'b1;
        @(negedge CLKIN);
        TX_SUCC = 1'b0;
        REQ_TX_RESP_ACK = 4'hF;
        @(negedge CLKIN);
        REQ_TX_RESP_ACK = 4'h0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (2) @(negedge CLKIN);
        vectors++; if (all_out !== 59'd0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        RESET = 1'b0;
    endtask

    task automatic test_single;
        REQ_TX_ADDR[23:16] = 8'h12;
        REQ_TX_DATA[95:64] = 32'hDEADBEEF;
        REQ_TX_REQ = 4'b0100;
        @(negedge CLKIN);
        vectors++; if (TX_REQ !== 1'b1) begin miscompares++; $display("FAIL single_tx_req: got %b expected 1", TX_REQ); end
        vectors++; if (TX_ADDR !== 8'h12) begin miscompares++; $display("FAIL single_addr: got %h expected 12", TX_ADDR); end
        vectors++; if (TX_DATA !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data: got %h expected deadbeef", TX_DATA); end
        vectors++; if (GRANT_ID !== 2'd2) begin miscompares++; $display("FAIL single_grant: got %0d expected 2", GRANT_ID); end
        vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", BUSY); end
        REQ_TX_REQ = 4'b0000;
        @(negedge CLKIN);
        vectors++; if (TX_REQ !== 1'b1) begin miscompares++; $display("FAIL single_hold_req: got %b expected 1", TX_REQ); end
        TX_ACK = 1'b1;
        @(negedge CLKIN);
        vectors++; if (REQ_TX_ACK !== 4'b0100) begin miscompares++; $display("FAIL single_req_ack: got %b expected 0100", REQ_TX_ACK); end
        vectors++; if (TX_REQ !== 1'b0) begin miscompares++; $display("FAIL single_req_drop: got %b expected 0", TX_REQ); end
        TX_ACK = 1'b0;
        @(negedge CLKIN);
        vectors++; if (REQ_TX_ACK !== 4'b0000) begin miscompares++; $display("FAIL single_ack_pulse: got %b expected 0000", REQ_TX_ACK); end
        TX_SUCC = 1'b1;
        @(negedge CLKIN);
        vectors++; if (REQ_TX_SUCC !== 4'b0100) begin miscompares++; $display("FAIL single_succ: got %b expected 0100", REQ_TX_SUCC); end
        vectors++; if (TX_RESP_ACK !== 1'b1) begin miscompares++; $display("FAIL single_resp_ack: got %b expected 1", TX_RESP_ACK); end
        TX_SUCC = 1'b0;
        REQ_TX_RESP_ACK = 4'b0100;
        @(negedge CLKIN);
        REQ_TX_RESP_ACK = 4'b0000;
        vectors++; if ({BUSY, TX_RESP_ACK, REQ_TX_SUCC} !== 6'd0) begin miscompares++; $display("FAIL single_release: got %b expected 000000", {BUSY, TX_RESP_ACK, REQ_TX_SUCC}); end
    endtask

    task automatic test_round_robin;
        apply_reset();
        REQ_TX_REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLKIN);
            vectors++; if ({TX_REQ, GRANT_ID} !== {1'b1, 2'(i % 4)}) begin miscompares++; $display("FAIL rr_grant_%0d: got req=%b id=%0d expected req=1 id=%0d", i, TX_REQ, GRANT_ID, i % 4); end
            if (i == 4) REQ_TX_REQ = 4'b0000;
            finish_msg();
        end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rr_idle: got %b expected 0", BUSY); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [3];
        logic        pends [3];
        words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
        pends[0] = 1'b1;          pends[1] = 1'b1;          pends[2] = 1'b0;
        apply_reset();
        REQ_TX_REQ = 4'b0001;
        @(negedge CLKIN);
        REQ_TX_REQ = 4'b0000;
        finish_msg();
        REQ_TX_ADDR[15:8] = 8'hA1;
        REQ_TX_DATA[63:32] = words[0];
        REQ_TX_PEND = 4'b0010;
        REQ_TX_REQ = 4'b0011;
        @(negedge CLKIN);
        vectors++; if ({GRANT_ID, TX_DATA, TX_PEND} !== {2'd1, words[0], 1'b1}) begin miscompares++; $display("FAIL b2b_first: got id=%0d data=%h pend=%b expected id=1 data=%h pend=1", GRANT_ID, TX_DATA, TX_PEND, words[0]); end
        for (int w = 0; w < 3; w++) begin
            TX_ACK = 1'b1;
            @(negedge CLKIN);
            vectors++; if ({REQ_TX_ACK, TX_REQ} !== 5'b0010_0) begin miscompares++; $display("FAIL b2b_ack_%0d: got ack=%b req=%b expected ack=0010 req=0", w, REQ_TX_ACK, TX_REQ); end
            TX_ACK = 1'b0;
            if (w < 2) begin
                REQ_TX_DATA[63:32] = words[w+1];
                REQ_TX_PEND = {2'b00, pends[w+1], 1'b0};
            end
            @(negedge CLKIN);
            if (w < 2) begin
                @(negedge CLKIN);
                vectors++; if ({TX_REQ, GRANT_ID, TX_DATA} !== {1'b1, 2'd1, words[w+1]}) begin miscompares++; $display("FAIL b2b_word_%0d: got req=%b id=%0d data=%h expected req=1 id=1 data=%h", w + 1, TX_REQ, GRANT_ID, TX_DATA, words[w+1]); end
            end
        end
        TX_SUCC = 1'b1;
        @(negedge CLKIN);
        vectors++; if (REQ_TX_SUCC !== 4'b0010) begin miscompares++; $display("FAIL b2b_succ: got %b expected 0010", REQ_TX_SUCC); end
        TX_SUCC = 1'b0;
        REQ_TX_RESP_ACK = 4'b0010;
        @(negedge CLKIN);
        REQ_TX_RESP_ACK = 4'b0000;
        @(negedge CLKIN);
        vectors++; if ({TX_REQ, GRANT_ID} !== {1'b1, 2'd0}) begin miscompares++; $display("FAIL b2b_wrap_grant: got req=%b id=%0d expected req=1 id=0", TX_REQ, GRANT_ID); end
        REQ_TX_REQ = 4'b0000;
        REQ_TX_PEND = 4'b0000;
        finish_msg();
    endtask

    task automatic test_fail_abort;
        REQ_TX_ADDR[31:24] = 8'h3C;
        REQ_TX_PEND = 4'b1000;
        REQ_TX_REQ = 4'b1000;
        @(negedge CLKIN);
        vectors++; if ({GRANT_ID, TX_ADDR, TX_PEND} !== {2'd3, 8'h3C, 1'b1}) begin miscompares++; $display("FAIL abort_grant: got id=%0d addr=%h pend=%b expected id=3 addr=3c pend=1", GRANT_ID, TX_ADDR, TX_PEND); end
        TX_ACK = 1'b1;
        @(negedge CLKIN);
        TX_ACK = 1'b0;
        @(negedge CLKIN);
        TX_FAIL = 1'b1;
        @(negedge CLKIN);
        vectors++; if ({REQ_TX_FAIL, REQ_TX_SUCC, TX_RESP_ACK, TX_REQ} !== 10'b1000_0000_1_0) begin miscompares++; $display("FAIL abort_fail: got fail=%b succ=%b rack=%b req=%b expected fail=1000 succ=0000 rack=1 req=0", REQ_TX_FAIL, REQ_TX_SUCC, TX_RESP_ACK, TX_REQ); end
        REQ_TX_RESP_ACK = 4'b1000;
        @(negedge CLKIN);
        vectors++; if ({REQ_TX_FAIL, TX_RESP_ACK, BUSY, TX_REQ} !== 7'b0000_1_1_0) begin miscompares++; $display("FAIL abort_hold: got fail=%b rack=%b busy=%b req=%b expected fail=0000 rack=1 busy=1 req=0", REQ_TX_FAIL, TX_RESP_ACK, BUSY, TX_REQ); end
        TX_FAIL = 1'b0;
        REQ_TX_RESP_ACK = 4'b0000;
        REQ_TX_REQ = 4'b0000;
        REQ_TX_PEND = 4'b0000;
        @(negedge CLKIN);
        vectors++; if ({BUSY, TX_REQ, TX_RESP_ACK} !== 3'b000) begin miscompares++; $display("FAIL abort_release: got busy=%b req=%b rack=%b expected 000", BUSY, TX_REQ, TX_RESP_ACK); end
    endtask

    task automatic test_reset_mid;
        REQ_TX_REQ = 4'b0010;
        @(negedge CLKIN);
        REQ_TX_REQ = 4'b0000;
        finish_msg();
        REQ_TX_REQ = 4'b0100;
        @(negedge CLKIN);
        vectors++; if ({TX_REQ, GRANT_ID} !== {1'b1, 2'd2}) begin miscompares++; $display("FAIL midreset_pre: got req=%b id=%0d expected req=1 id=2", TX_REQ, GRANT_ID); end
        RESET = 1'b1;
        REQ_TX_REQ = 4'b0000;
        @(negedge CLKIN);
        vectors++; if (all_out !== 59'd0) begin miscompares++; $display("FAIL midreset_outputs: got %h expected 0", all_out); end
        RESET = 1'b0;
        REQ_TX_REQ = 4'b0110;
        @(negedge CLKIN);
        vectors++; if (GRANT_ID !== 2'd1) begin miscompares++; $display("FAIL midreset_rr: got %0d expected 1", GRANT_ID); end
        REQ_TX_REQ = 4'b0000;
        finish_msg();
    endtask

    task automatic test_priority;
        apply_reset();
        REQ_TX_REQ = 4'b0011;
        REQ_PRIORITY = 4'b0010;
        @(negedge CLKIN);
`ifdef ULPB_TX_ARB_PRIORITY_EN
        vectors++; if ({GRANT_ID, PRIORITY} !== {2'd1, 1'b1}) begin miscompares++; $display("FAIL prio_grant: got id=%0d prio=%b expected id=1 prio=1", GRANT_ID, PRIORITY); end
`else
        vectors++; if ({GRANT_ID, PRIORITY} !== {2'd0, 1'b0}) begin miscompares++; $display("FAIL prio_grant: got id=%0d prio=%b expected id=0 prio=0", GRANT_ID, PRIORITY); end
`endif
        REQ_TX_REQ = 4'b0000;
        REQ_PRIORITY = 4'b0000;
        finish_msg();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_fail_abort();
        test_reset_mid();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ulpb_tx_arbiter.md
ULPB_TX_ARBITER -- requirements
Module: ulpb_tx_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. The clock is CLKIN and the reset is RESET; there are no parameters, and widths are ADDR_WIDTH=8 and DATA_WIDTH=32 from ulpb_def.
REQ-002 CLKIN  in  1  rising-edge clock.
REQ-003 RESET  in  1  synchronous active-high reset.
REQ-004 REQ_TX_REQ  in  4  per-requester word request; requester i drives bit i.
REQ-005 REQ_TX_PEND  in  4  per-requester "more words follow" flag.
REQ-006 REQ_PRIORITY  in  4  per-requester priority flag.
REQ-007 REQ_TX_ADDR  in  32  requester i address at [8i+7:8i].
REQ-008 REQ_TX_DATA  in  128  requester i data at [32i+31:32i].
REQ-009 REQ_TX_RESP_ACK  in  4  requester acknowledge of SUCC/FAIL.
REQ-010 REQ_TX_ACK  out  4  per-requester word accepted.
REQ-011 REQ_TX_SUCC, REQ_TX_FAIL  out  4 each  per-requester message result.
REQ-012 TX_ADDR, TX_DATA  out  8, 32  to node; registered.
REQ-013 TX_REQ, TX_PEND, PRIORITY  out  1 each  to node; registered.
REQ-014 TX_ACK, TX_SUCC, TX_FAIL  in  1 each  from node.
REQ-015 TX_RESP_ACK  out  1  to node.
REQ-016 BUSY  out  1  set while a message is owned. GRANT_ID  out  2  index of the owner.

Function
REQ-017 SHALL implement the following FSM: IDLE, SEND (TX_REQ=1), ACKLOW (TX_REQ=0), NEXT, RESULT, RESPACK.
REQ-018 IDLE, any REQ_TX_REQ set: SHALL choose the winner by round-robin starting at pointer RR. It SHALL latch the winner's ADDR, DATA, PEND and PRIORITY, set BUSY and GRANT_ID, and enter SEND. TX_REQ SHALL be high on the next cycle, giving 1-cycle latency.
REQ-019 SEND, TX_ACK=1: SHALL drop TX_REQ and pulse REQ_TX_ACK[owner] for 1 cycle, then go to ACKLOW.
REQ-020 ACKLOW, TX_ACK=0: SHALL go to NEXT if the latched PEND=1, else to RESULT.
REQ-021 NEXT, REQ_TX_REQ[owner]=1: SHALL relatch that requester's word and re-enter SEND. Other requesters SHALL be ignored until the message ends, so the owner stays locked for multi-word messages.
REQ-022 In SEND, ACKLOW, NEXT or RESULT, if TX_SUCC or TX_FAIL=1: SHALL copy the value to REQ_TX_SUCC/FAIL[owner], assert TX_RESP_ACK, and enter RESPACK. TX_FAIL seen mid-message SHALL abort the remaining words.
REQ-023 RESPACK: SHALL hold TX_RESP_ACK until TX_SUCC=TX_FAIL=0. It SHALL hold REQ_TX_SUCC/FAIL[owner] until REQ_TX_RESP_ACK[owner]=1. When both conditions are met, it SHALL clear everything, set RR=owner+1 mod 4, clear BUSY, and return to IDLE.
REQ-024 Dropping REQ_TX_REQ[owner] while in SEND SHALL NOT retract TX_REQ.
REQ-025 Only REQ_*[owner] SHALL ever be driven non-zero. Non-owner outputs SHALL stay 0.
REQ-026 Simultaneous requests SHALL be resolved in a single cycle. RR wraps 3 to 0.

Reset
REQ-027 RESET high on any edge SHALL force IDLE and RR=0 regardless of state, including mid-message.
REQ-028 RESET SHALL drive every output to 0: TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, TX_ADDR, TX_DATA, BUSY, GRANT_ID, REQ_TX_ACK, REQ_TX_SUCC and REQ_TX_FAIL.

Configuration
REQ-029 With macro ULPB_TX_ARB_PRIORITY_EN defined, the IDLE arbitration SHALL consider only requesters with both REQ_TX_REQ and REQ_PRIORITY set, round-robin among them. If none qualify it SHALL fall back to plain round-robin. PRIORITY SHALL equal the latched flag.
REQ-030 Without ULPB_TX_ARB_PRIORITY_EN, REQ_PRIORITY SHALL be ignored and PRIORITY SHALL be tied to 0.

Verification
REQ-031 After reset, REQ_TX_REQ=4'b0100 with addr 8'h12 and data 32'hDEADBEEF: next cycle TX_REQ=1, TX_ADDR=12, TX_DATA=DEADBEEF, GRANT_ID=2. On TX_ACK, REQ_TX_ACK=4'b0100 for 1 cycle. TX_SUCC then gives REQ_TX_SUCC=4'b0100 and TX_RESP_ACK=1.
REQ-032 REQ_TX_REQ=4'b1111 held for four messages: grants are issued in the order 0,1,2,3. A fifth message is granted to 0.
REQ-033 Requester 1 sends 3 words with PEND=1,1,0 while requester 0 is requesting: all 3 words go to requester 1 with no interleaving, then requester 0 is granted (RR=2 wraps to 0).
REQ-034 TX_FAIL=1 in NEXT after word 1 of 3: REQ_TX_FAIL[owner]=1, no further TX_REQ, and the FSM returns to IDLE after both acks.
REQ-035 RESET asserted in SEND with TX_REQ=1: next cycle all outputs are 0, BUSY=0, and RR=0.
REQ-036 With ULPB_TX_ARB_PRIORITY_EN, REQ_TX_REQ=4'b0011 and REQ_PRIORITY=4'b0010 at RR=0: requester 1 is granted and PRIORITY=1. Without the macro, requester 0 is granted and PRIORITY=0.
